serial_bit_feeder: RTL and testbench

SERIAL_BIT_FEEDER -- requirements
Module: serial_bit_feeder

---
 rtl/serial_bit_feeder.sv | 106 ++++++++++
 tb/tb_serial_bit_feeder.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial bit feeder with a ready/valid word input and a registered serial output.
// Optional trailing even-parity bit when SERIAL_BIT_FEEDER_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | no word in flight, ready for a transfer
// SHIFT  | presenting data bits, counter counts down to the last bit
// PARITY | presenting the even-parity bit of the word (parity build only)
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  logic parity_q;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             last_bit;
  logic             head_bit;
  logic             take;

  assign last_bit = (cnt == '0);
  assign head_bit = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign take     = in_valid & in_ready;
  assign busy     = bit_valid;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    word_done = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        bit_valid = 1'b1;
        bit_out   = head_bit;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
        if (last_bit) state_nxt = PARITY;
`else
        if (last_bit) begin
          in_ready  = 1'b1;
          word_done = 1'b1;
          state_nxt = in_valid ? SHIFT : IDLE;
        end
`endif
      end
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
      PARITY: begin
        bit_valid = 1'b1;
        bit_out   = parity_q;
        in_ready  = 1'b1;
        word_done = 1'b1;
        state_nxt = in_valid ? SHIFT : IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // A transfer always reloads, so back-to-back words need no idle cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (take) begin
        shreg <= in_data;
        cnt   <= CNT_LOAD;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
        parity_q <= ^in_data;
`endif
      end else if (state == SHIFT) begin
        shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
        if (!last_bit) cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: MSB-first and LSB-first instances share stimulus and are
// checked every cycle against a queue-of-pending-bits model.
module tb_serial_bit_feeder;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       rdy_m, bo_m, bv_m, busy_m, wd_m;
  logic       rdy_l, bo_l, bv_l, busy_l, wd_l;

  int vectors = 0;
  int miscompares = 0;

  bit q_m[$];
  bit q_l[$];
  logic [31:0] cap_m = '0;
  logic [31:0] cap_l = '0;
  int nvalid_m = 0;

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_m), .bit_out(bo_m), .bit_valid(bv_m), .busy(busy_m), .word_done(wd_m)
  );

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rdy_l), .bit_out(bo_l), .bit_valid(bv_l), .busy(busy_l), .word_done(wd_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic r, input logic v, input logic [7:0] d);
    bit take_m, take_l;
    reset = r; in_valid = v; in_data = d;
    #1;
    chk("m_valid", bv_m, q_m.size() > 0);
    chk("m_bit",   bo_m, q_m.size() > 0 ? q_m[0] : 1'b0);
    chk("m_busy",  busy_m, q_m.size() > 0);
    chk("m_done",  wd_m, q_m.size() == 1);
    chk("m_ready", rdy_m, q_m.size() <= 1);
    chk("l_valid", bv_l, q_l.size() > 0);
    chk("l_bit",   bo_l, q_l.size() > 0 ? q_l[0] : 1'b0);
    chk("l_busy",  busy_l, q_l.size() > 0);
    chk("l_done",  wd_l, q_l.size() == 1);
    chk("l_ready", rdy_l, q_l.size() <= 1);
    if (bv_m === 1'b1) begin cap_m = {cap_m[30:0], bo_m}; nvalid_m++; end
    if (bv_l === 1'b1) cap_l = {cap_l[30:0], bo_l};
    take_m = r && v && (q_m.size() <= 1);
    take_l = r && v && (q_l.size() <= 1);
    @(posedge clk);
    if (!r) begin
      q_m.delete();
      q_l.delete();
    end else begin
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (q_l.size() > 0) void'(q_l.pop_front());
      if (take_m) begin
        for (int i = 7; i >= 0; i--) q_m.push_back(d[i]);
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
        q_m.push_back(^d);
`endif
      end
      if (take_l) begin
        for (int i = 0; i < 8; i++) q_l.push_back(d[i]);
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
        q_l.push_back(^d);
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 8'h00);
  endtask

  int snap;

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0;
    @(posedge clk);
    @(negedge clk);

    // reset state
    step(1'b0, 1'b0, 8'h00);
    idle(2);

    // single word, MSB first
    step(1'b1, 1'b1, 8'hB4);
    idle(10);
    chk("msb_b4_stream", cap_m[7:0], 8'hB4);

    // back-to-back words with valid held high
    step(1'b1, 1'b1, 8'hB4);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 8'h5A);
    idle(10);
    chk("b2b_stream", cap_m[15:0], 16'hB45A);

    // LSB first on the second instance
    step(1'b1, 1'b1, 8'h01);
    idle(10);
    chk("lsb_01_stream", cap_l[7:0], 8'h80);

    // reset on the third bit aborts the word
    step(1'b1, 1'b1, 8'hFF);
    idle(2);
    step(1'b0, 1'b0, 8'h00);
    snap = nvalid_m;
    idle(10);
    chk("abort_no_bits", nvalid_m - snap, 0);

    // mid-word pulse is ignored
    step(1'b1, 1'b1, 8'h5A);
    idle(2);
    step(1'b1, 1'b1, 8'hFF);
    idle(10);
    chk("ignore_midword", cap_m[7:0], 8'h5A);

    // reset beats a simultaneous transfer
    snap = nvalid_m;
    step(1'b0, 1'b1, 8'hA5);
    idle(3);
    chk("reset_vs_xfer", nvalid_m - snap, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) != 0), 8'($urandom));
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
